uart8_rx_fifo: RTL and testbench
================================

# uart8_rx_fifo

Receive-side byte buffer that sits directly downstream of the `Uart8` receiver. It captures each completed byte (with its framing-error flag) on the receiver's done indication and holds it in a first-word-fall-through FIFO. The consumer drains it with a valid/ready handshake, so rx bytes are not lost while the consumer is busy.

## Interface
- `DEPTH`, 16, number of entries; power of two, 2..256.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rxDone`  in  1  receiver done; a byte is pushed on each 0→1 transition as sampled by `clk`.
- `rxErr`  in  1  receiver error flag; sampled together with `rxDone` and stored with the byte.
- `in`  in  8  received byte from the receiver's `out`.
- `rdValid`  out  1  FIFO non-empty; head entry presented.
- `rdReady`  in  1  consumer accepts head entry when `rdValid && rdReady`.
- `rdData`  out  8  head byte; 8'h00 when empty.
- `rdErr`  out  1  head entry error flag; 0 when empty.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when a push is dropped.
- `clearOverflow`  in  1  synchronous clear of `overflow`.

## Operation
- Edge detect: register `rxDonePrev`; push request = `rxDone && !rxDonePrev`. A level held high for many cycles yields exactly one push.
- Storage: DEPTH × 9 bits {err, byte}; write pointer and read pointer of $clog2(DEPTH) bits, wrapping naturally modulo DEPTH; separate occupancy counter disambiguates full/empty.
- Pop = `rdValid && rdReady`; advances read pointer.
- Push when `count < DEPTH`: write {rxErr, in} at write pointer, advance it.
- Push when `count == DEPTH` and no pop: byte dropped, pointers unchanged, `overflow` ← 1.
- Push when `count == DEPTH` with simultaneous pop: both performed, `count` stays DEPTH, no overflow.
- Push and pop when `count` is 1..DEPTH-1: both performed, `count` unchanged.
- Pop when empty: impossible (`rdValid` = 0); `rdReady` ignored.
- `overflow`: a push being dropped in the same cycle as `clearOverflow` takes priority (flag stays 1).
- `rdData`/`rdErr` are the memory head entry gated by `rdValid`.

## Timing
- Reset (async): pointers 0, `count` 0, `rxDonePrev` 0, `overflow` 0 → `rdValid` 0, `rdData` 8'h00, `rdErr` 0. Memory contents not reset.
- If `rxDone` is already high when reset is released, a push occurs on the first clock edge (prev = 0).
- Push latency: the edge that samples `rxDone` 0→1 writes the entry; `rdValid`/`count` reflect it immediately after that edge (1 cycle from input to output).
- Pop: entry removed at the accepting edge; the next entry (if any) is presented in the same following cycle; back-to-back pops at 1 per clock.
- Max throughput is 1 push per 2 clocks (edge detect); the receiver is far slower.
- Reset mid-operation discards all entries and the overflow flag immediately.

## Configuration
- `UART8_RX_FIFO_DROP_ERR_EN`: when defined, a push with `rxErr` = 1 is discarded (no write, no `count` change, no overflow) and `rdErr` is tied 0. When undefined, errored bytes are stored and flagged via `rdErr` as described above.

## Test plan
- Reset, then `in`=8'h35, `rxErr`=0, pulse `rxDone` 1 cycle, `rdReady`=0 → next cycle `rdValid`=1, `rdData`=8'h35, `rdErr`=0, `count`=1; assert `rdReady` one cycle → `rdValid`=0, `count`=0, `rdData`=8'h00.
- Hold `rxDone` high 20 cycles with `in`=8'hA5 → exactly one entry, `count`=1.
- DEPTH=16: push 8'h00..8'h0F, then 8'hFF with `rdReady`=0 → `count`=16, `overflow`=1; drain → 8'h00..8'h0F in order, 8'hFF absent; `clearOverflow` → `overflow`=0.
- Full FIFO, push 8'h42 coinciding with pop → `count` stays 16, `overflow`=0, 8'h42 read last.
- Push 8'h7E with `rxErr`=1 → without macro: `rdData`=8'h7E, `rdErr`=1; with `UART8_RX_FIFO_DROP_ERR_EN`: `rdValid` stays 0, `count`=0.
- Push 3 bytes, assert `rst` mid-cycle asynchronously → `rdValid`, `count`, `overflow` go 0 without waiting for a clock edge.

Source files
------------

// File: rtl/uart8_rx_fifo_if.sv
// rtl/uart8_rx_fifo_if.sv - receiver-to-consumer bundle for uart8_rx_fifo
interface uart8_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rxDone;
  logic          rxErr;
  logic [7:0]    in;
  logic          rdValid;
  logic          rdReady;
  logic [7:0]    rdData;
  logic          rdErr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clearOverflow;

  // Receiver and consumer side
  modport master (
    output rxDone, rxErr, in, rdReady, clearOverflow,
    input  rdValid, rdData, rdErr, count, overflow
  );

  // FIFO side
  modport slave (
    input  rxDone, rxErr, in, rdReady, clearOverflow,
    output rdValid, rdData, rdErr, count, overflow
  );
endinterface

// File: rtl/uart8_rx_fifo.sv
// rtl/uart8_rx_fifo.sv - FWFT byte FIFO behind Uart8 rx; option UART8_RX_FIFO_DROP_ERR_EN
module uart8_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart8_rx_fifo_if.slave       bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_done_prev;
  logic          r_overflow;

  logic          w_push_req;
  logic          w_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [8:0]    w_head;

`ifdef UART8_RX_FIFO_DROP_ERR_EN
  // Errored bytes never reach storage, so they cannot count as pushes or overflows
  assign w_push_req = bus.rxDone & ~r_done_prev & ~bus.rxErr;
`else
  assign w_push_req = bus.rxDone & ~r_done_prev;
`endif

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = w_valid & bus.rdReady;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & w_full & ~w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  // Rising-edge detect on rxDone so a held level produces one push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_done_prev <= 1'b0;
    else     r_done_prev <= bus.rxDone;
  end

  // Storage is not reset; only the pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.rxErr, bus.in};
  end

  // Pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy tracks push/pop separately to tell full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_count <= '0;
    else if (w_push & ~w_pop) r_count <= r_count + CW'(1);
    else if (~w_push & w_pop) r_count <= r_count - CW'(1);
  end

  // Sticky overflow; a drop in the clearing cycle keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_overflow <= 1'b0;
    else if (w_drop)            r_overflow <= 1'b1;
    else if (bus.clearOverflow) r_overflow <= 1'b0;
  end

  assign bus.rdValid  = w_valid;
  assign bus.rdData   = w_valid ? w_head[7:0] : 8'h00;
`ifdef UART8_RX_FIFO_DROP_ERR_EN
  assign bus.rdErr    = 1'b0;
`else
  assign bus.rdErr    = w_valid & w_head[8];
`endif
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_uart8_rx_fifo.sv
// tb/tb_uart8_rx_fifo.sv - self-checking bench for uart8_rx_fifo
module tb_uart8_rx_fifo;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  uart8_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart8_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of {err, byte} plus an occupancy integer
  logic [8:0] mq [$];
  int         m_cnt;
  logic       m_prev;
  logic       m_ovf;
  logic       m_req;
  logic       m_pop;
  logic       m_do_push;

  always_comb begin
    m_req = bus.rxDone && !m_prev;
`ifdef UART8_RX_FIFO_DROP_ERR_EN
    if (bus.rxErr) m_req = 1'b0;
`endif
    m_pop     = (m_cnt != 0) && bus.rdReady;
    m_do_push = m_req && ((m_cnt < DEPTH) || m_pop);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_cnt  <= 0;
      m_prev <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_do_push) mq.push_back({bus.rxErr, bus.in});
      m_cnt  <= m_cnt + (m_do_push ? 1 : 0) - (m_pop ? 1 : 0);
      m_prev <= bus.rxDone;
      if (m_req && !m_do_push) m_ovf <= 1'b1;
      else if (bus.clearOverflow) m_ovf <= 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every cycle, away from the rising edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_valid", int'(bus.rdValid), (m_cnt != 0) ? 1 : 0);
      chk("cyc_data",  int'(bus.rdData),  (m_cnt != 0) ? int'(mq[0][7:0]) : 0);
      chk("cyc_err",   int'(bus.rdErr),   (m_cnt != 0) ? int'(mq[0][8]) : 0);
      chk("cyc_count", int'(bus.count),   m_cnt);
      chk("cyc_ovf",   int'(bus.overflow), int'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic e);
    bus.in     = b;
    bus.rxErr  = e;
    bus.rxDone = 1'b1;
    tick();
    bus.rxDone = 1'b0;
    bus.rxErr  = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.rxDone = 1'b0;
    bus.rxErr  = 1'b0;
    bus.in     = 8'h00;
    bus.rdReady = 1'b0;
    bus.clearOverflow = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", int'(bus.rdValid), 0);
    chk("rst_data",  int'(bus.rdData), 8'h00);
    chk("rst_err",   int'(bus.rdErr), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_ovf",   int'(bus.overflow), 0);

    // Single byte, one-cycle pulse
    bus.in = 8'h35;
    bus.rxDone = 1'b1;
    tick();
    bus.rxDone = 1'b0;
    chk("one_valid", int'(bus.rdValid), 1);
    chk("one_data",  int'(bus.rdData), 8'h35);
    chk("one_err",   int'(bus.rdErr), 0);
    chk("one_count", int'(bus.count), 1);
    bus.rdReady = 1'b1;
    tick();
    bus.rdReady = 1'b0;
    chk("pop_valid", int'(bus.rdValid), 0);
    chk("pop_count", int'(bus.count), 0);
    chk("pop_data",  int'(bus.rdData), 8'h00);

    // Held level yields one entry
    bus.in = 8'hA5;
    bus.rxDone = 1'b1;
    repeat (20) tick();
    bus.rxDone = 1'b0;
    tick();
    chk("hold_count", int'(bus.count), 1);
    chk("hold_data",  int'(bus.rdData), 8'hA5);
    chk("hold_model", m_cnt, 1);
    bus.rdReady = 1'b1;
    tick();
    bus.rdReady = 1'b0;

    // Fill, overflow, drain in order, clear
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
    push_byte(8'hFF, 1'b0);
    chk("full_count", int'(bus.count), 16);
    chk("full_ovf",   int'(bus.overflow), 1);
    chk("full_model", m_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", int'(bus.rdData), i);
      bus.rdReady = 1'b1;
      tick();
    end
    bus.rdReady = 1'b0;
    chk("drain_count", int'(bus.count), 0);
    chk("drain_ovf_held", int'(bus.overflow), 1);
    bus.clearOverflow = 1'b1;
    tick();
    bus.clearOverflow = 1'b0;
    chk("clr_ovf", int'(bus.overflow), 0);

    // Full FIFO with push coinciding with pop
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i), 1'b0);
    bus.in = 8'h42;
    bus.rxDone = 1'b1;
    bus.rdReady = 1'b1;
    tick();
    bus.rxDone = 1'b0;
    bus.rdReady = 1'b0;
    chk("pp_count", int'(bus.count), 16);
    chk("pp_ovf",   int'(bus.overflow), 0);
    tick();
    for (int i = 1; i < 17; i++) begin
      chk("pp_data", int'(bus.rdData), (i == 16) ? 8'h42 : 8'h10 + i);
      bus.rdReady = 1'b1;
      tick();
    end
    bus.rdReady = 1'b0;
    chk("pp_empty", int'(bus.rdValid), 0);

    // Errored byte
    push_byte(8'h7E, 1'b1);
`ifdef UART8_RX_FIFO_DROP_ERR_EN
    chk("err_valid", int'(bus.rdValid), 0);
    chk("err_count", int'(bus.count), 0);
    chk("err_ovf",   int'(bus.overflow), 0);
`else
    chk("err_valid", int'(bus.rdValid), 1);
    chk("err_data",  int'(bus.rdData), 8'h7E);
    chk("err_flag",  int'(bus.rdErr), 1);
    bus.rdReady = 1'b1;
    tick();
    bus.rdReady = 1'b0;
`endif

    // Overflow then async reset mid-cycle with entries present
    for (int i = 0; i < 17; i++) push_byte(8'(8'h60 + i), 1'b0);
    chk("pre_rst_ovf", int'(bus.overflow), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(bus.rdValid), 0);
    chk("arst_count", int'(bus.count), 0);
    chk("arst_ovf",   int'(bus.overflow), 0);
    chk("arst_data",  int'(bus.rdData), 0);
    bus.in = 8'h5A;
    bus.rxDone = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.rxDone = 1'b0;
    chk("rel_count", int'(bus.count), 1);
    chk("rel_data",  int'(bus.rdData), 8'h5A);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
